// File: rtl/wrdm_desc_arbiter_pkg.sv
// Shared WRDM descriptor types and arbiter state encoding.
// pcie_desc_t is the layout the write-data-mover consumes; desc_id sits at bits [153:146].
package wrdm_desc_arbiter_pkg;

  localparam int WRDM_DESC_WIDTH = 174;
  localparam int DESC_ID_WIDTH   = 8;

  typedef struct packed {
    logic [19:0]              rsvd;
    logic [DESC_ID_WIDTH-1:0] desc_id;
    logic [17:0]              length;
    logic [63:0]              dst_addr;
    logic [63:0]              src_addr;
  } pcie_desc_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/desc_skid_buffer.sv
// Two-entry registered valid/ready stage; output and input-ready come straight from flops.
// Also used on the RDDM descriptor path.
module desc_skid_buffer #(
  parameter int DESC_WIDTH = 174
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_valid,
  input  logic [DESC_WIDTH-1:0] i_in_data,
  output logic                  o_in_ready,
  output logic                  o_out_valid,
  output logic [DESC_WIDTH-1:0] o_out_data,
  input  logic                  i_out_ready
);

  logic                  r_head_vld;
  logic                  r_tail_vld;
  logic [DESC_WIDTH-1:0] r_head_data;
  logic [DESC_WIDTH-1:0] r_tail_data;
  logic                  w_push;
  logic                  w_pop;

  // The tail entry is only ever occupied while the head is, so tail-valid alone means full.
  assign o_in_ready  = ~r_tail_vld;
  assign w_push      = i_in_valid & ~r_tail_vld;
  assign w_pop       = r_head_vld & i_out_ready;
  assign o_out_valid = r_head_vld;
  assign o_out_data  = r_head_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_vld  <= 1'b0;
      r_tail_vld  <= 1'b0;
      r_head_data <= '0;
      r_tail_data <= '0;
    end else if (r_tail_vld) begin
      if (w_pop) begin
        r_head_data <= r_tail_data;
        r_tail_vld  <= 1'b0;
      end
    end else if (r_head_vld) begin
      if (w_push && w_pop) begin
        r_head_data <= i_in_data;
      end else if (w_push) begin
        r_tail_data <= i_in_data;
        r_tail_vld  <= 1'b1;
      end else if (w_pop) begin
        r_head_vld <= 1'b0;
      end
    end else if (w_push) begin
      r_head_data <= i_in_data;
      r_head_vld  <= 1'b1;
    end
  end

endmodule

// File: rtl/wrdm_desc_arbiter.sv
// Burst-granular round-robin arbiter sharing the WRDM descriptor port between DMA engines.
// Stamps a running descriptor ID and registers the output through a 2-entry skid buffer.
module wrdm_desc_arbiter
  import wrdm_desc_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS    = 4,
  parameter  int DESC_WIDTH   = WRDM_DESC_WIDTH,
  parameter  int ID_WIDTH     = DESC_ID_WIDTH,
  parameter  int OVERWRITE_ID = 1,
  localparam int PW           = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS*DESC_WIDTH-1:0] req_data,
  input  logic [NUM_PORTS-1:0]            req_last,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic                            wrdm_desc_valid,
  output logic [DESC_WIDTH-1:0]           wrdm_desc_data,
  input  logic                            wrdm_desc_ready,
  output logic [PW-1:0]                   owner,
  output logic                            locked,
  output logic [ID_WIDTH-1:0]             next_desc_id
);

  arb_state_t            r_state;
  logic [PW-1:0]         r_owner;
  logic [PW-1:0]         r_rr_ptr;
  logic                  r_locked;
  logic [ID_WIDTH-1:0]   r_next_id;
  logic                  w_skid_ready;
  logic                  w_acc;
  logic                  w_own_valid;
  logic                  w_own_last;
  logic [DESC_WIDTH-1:0] w_own_data;
  pcie_desc_t            w_stamp;

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] p);
    return (p == PW'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requesting port at or after ptr, wrapping modulo NUM_PORTS.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_PORTS-1:0] v,
                                            input logic [PW-1:0]        ptr);
    logic [PW-1:0] g;
    logic [PW-1:0] idx;
    logic          found;
    g     = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && v[idx]) begin
        g     = idx;
        found = 1'b1;
      end
      idx = rr_next(idx);
    end
    return g;
  endfunction

  always_comb begin
    w_own_data  = '0;
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_owner == PW'(i)) begin
        w_own_data  = req_data[i*DESC_WIDTH +: DESC_WIDTH];
        w_own_valid = req_valid[i];
        w_own_last  = req_last[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == LOCKED) req_ready[r_owner] = w_skid_ready;
  end

  assign w_acc = (r_state == LOCKED) & w_own_valid & w_skid_ready;

  always_comb begin
    w_stamp = pcie_desc_t'(w_own_data);
    if (OVERWRITE_ID != 0) w_stamp.desc_id = DESC_ID_WIDTH'(r_next_id);
  end

  // Grant is registered in IDLE, so every burst pays exactly one arbitration cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_locked  <= 1'b0;
      r_next_id <= '0;
    end else begin
      if (w_acc) r_next_id <= r_next_id + 1'b1;
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_owner  <= rr_pick(req_valid, r_rr_ptr);
            r_locked <= 1'b1;
            r_state  <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_acc && w_own_last) begin
            r_rr_ptr <= rr_next(r_owner);
            r_locked <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign owner        = r_owner;
  assign locked       = r_locked;
  assign next_desc_id = r_next_id;

  desc_skid_buffer #(
    .DESC_WIDTH(DESC_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (w_acc),
    .i_in_data   (w_stamp),
    .o_in_ready  (w_skid_ready),
    .o_out_valid (wrdm_desc_valid),
    .o_out_data  (wrdm_desc_data),
    .i_out_ready (wrdm_desc_ready)
  );

endmodule

// File: tb/tb_wrdm_desc_arbiter.sv
// Bench for wrdm_desc_arbiter: randomized requesters against a transaction-level model
// (grant queue, in-flight descriptor queue, ID counter); a second instance passes IDs through.
module tb_wrdm_desc_arbiter;
  import wrdm_desc_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 174;
  localparam int IW = 8;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready, req_ready_pt;
  logic [N*DW-1:0] req_data;
  logic            wrdm_valid, wrdm_valid_pt, wrdm_ready;
  logic [DW-1:0]   wrdm_data, wrdm_data_pt;
  logic [PW-1:0]   owner, owner_pt;
  logic            locked, locked_pt;
  logic [IW-1:0]   nid, nid_pt;

  always #5 clk = ~clk;

  wrdm_desc_arbiter #(.NUM_PORTS(N), .DESC_WIDTH(DW), .ID_WIDTH(IW), .OVERWRITE_ID(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .wrdm_desc_valid(wrdm_valid), .wrdm_desc_data(wrdm_data),
    .wrdm_desc_ready(wrdm_ready), .owner(owner), .locked(locked), .next_desc_id(nid));

  wrdm_desc_arbiter #(.NUM_PORTS(N), .DESC_WIDTH(DW), .ID_WIDTH(IW), .OVERWRITE_ID(0)) dut_pt (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready_pt), .wrdm_desc_valid(wrdm_valid_pt), .wrdm_desc_data(wrdm_data_pt),
    .wrdm_desc_ready(wrdm_ready), .owner(owner_pt), .locked(locked_pt), .next_desc_id(nid_pt));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit            m_locked;
  int            m_owner, m_ptr, m_nid;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_qr[$];

  // Requester state
  bit            p_valid[N];
  bit            p_last[N];
  logic [DW-1:0] p_data[N];
  int            p_rem[N], p_plan[N], p_pres[N], p_start[N];
  bit            acc_prev[N];
  int            wr_pct;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_desc();
    logic [191:0] t;
    for (int k = 0; k < 6; k++) t[k*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  function automatic void model_clear();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_nid = 0;
    m_q.delete(); m_qr.delete();
  endfunction

  function automatic bit all_idle();
    bit r;
    r = !m_locked && (m_q.size() == 0);
    for (int i = 0; i < N; i++)
      if (p_valid[i] || p_rem[i] != 0 || p_plan[i] != 0) r = 0;
    return r;
  endfunction

  task automatic step(input bit do_rst);
    logic [N-1:0] exp_rdy;
    bit           acc[N];
    bit           pop;
    pcie_desc_t   s;
    logic [DW-1:0] sv;
    @(negedge clk);
    exp_rdy = '0;
    if (m_locked && m_q.size() < 2) exp_rdy[m_owner[PW-1:0]] = 1'b1;
    check_eq("locked", DW'(locked), DW'(m_locked));
    check_eq("owner", DW'(owner), DW'(m_owner));
    check_eq("next_desc_id", DW'(nid), DW'(m_nid));
    check_eq("req_ready", DW'(req_ready), DW'(exp_rdy));
    check_eq("wrdm_valid", DW'(wrdm_valid), DW'(m_q.size() != 0));
    check_eq("pt_req_ready", DW'(req_ready_pt), DW'(exp_rdy));
    check_eq("pt_wrdm_valid", DW'(wrdm_valid_pt), DW'(m_qr.size() != 0));
    if (m_q.size() != 0) begin
      check_eq("wrdm_data", wrdm_data, m_q[0]);
      check_eq("pt_wrdm_data", wrdm_data_pt, m_qr[0]);
    end
    // Drive this cycle's inputs, honouring hold-until-accepted
    rst = do_rst;
    for (int i = 0; i < N; i++) begin
      if (do_rst) begin
        p_valid[i] = 0; p_rem[i] = 0; p_plan[i] = 0;
      end else if (!(p_valid[i] && !acc_prev[i])) begin
        p_valid[i] = 0;
        if (p_rem[i] == 0) begin
          if (p_plan[i] > 0) begin
            p_rem[i] = p_plan[i]; p_plan[i] = 0;
          end else if (int'($urandom_range(99)) < p_start[i]) begin
            p_rem[i] = int'($urandom_range(4, 1));
          end
        end
        if (p_rem[i] > 0 && int'($urandom_range(99)) < p_pres[i]) begin
          p_valid[i] = 1; p_last[i] = (p_rem[i] == 1); p_data[i] = rand_desc();
        end
      end
      req_valid[i] = p_valid[i];
      req_last[i]  = p_valid[i] & p_last[i];
      req_data[i*DW +: DW] = p_data[i];
    end
    wrdm_ready = (int'($urandom_range(99)) < wr_pct);
    // Predict what the coming clock edge does
    for (int i = 0; i < N; i++) acc[i] = 0;
    if (do_rst) begin
      model_clear();
    end else begin
      pop = (m_q.size() != 0) && wrdm_ready;
      if (pop) begin
        void'(m_q.pop_front()); void'(m_qr.pop_front());
      end
      if (m_locked) begin
        acc[m_owner] = exp_rdy[m_owner[PW-1:0]] && p_valid[m_owner];
        if (acc[m_owner]) begin
          s = pcie_desc_t'(p_data[m_owner]);
          m_qr.push_back(p_data[m_owner]);
          s.desc_id = 8'(m_nid);
          sv = s;
          m_q.push_back(sv);
          m_nid = (m_nid + 1) % 256;
          p_rem[m_owner]--;
          if (p_last[m_owner]) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N;
          end
        end
      end else begin
        for (int k = N - 1; k >= 0; k--)
          if (p_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        for (int k = 0; k < N; k++)
          if (p_valid[k]) m_locked = 1;
      end
    end
    for (int i = 0; i < N; i++) acc_prev[i] = acc[i];
  endtask

  task automatic run_until_idle(input int maxc);
    int c = 0;
    do begin
      step(0); c++;
    end while (!all_idle() && c < maxc);
    if (!all_idle()) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", maxc);
    end
  endtask

  initial begin
    rst = 1; req_valid = '0; req_last = '0; req_data = '0; wrdm_ready = 0; wr_pct = 100;
    for (int i = 0; i < N; i++) begin
      p_valid[i] = 0; p_last[i] = 0; p_data[i] = '0; p_rem[i] = 0; p_plan[i] = 0;
      p_pres[i] = 100; p_start[i] = 0; acc_prev[i] = 0;
    end
    model_clear();
    repeat (2) @(posedge clk);

    // Single-port 3-descriptor burst and latency
    step(0);
    p_plan[1] = 3;
    step(0); step(0);
    check_eq("t1_no_early_out", DW'(wrdm_valid), DW'(1'b0));
    step(0);
    check_eq("t1_latency2", DW'(wrdm_valid), DW'(1'b1));
    run_until_idle(30);

    // Contention and round-robin pointer
    step(1);
    p_plan[0] = 2; p_plan[2] = 2;
    step(0); step(0);
    check_eq("t2_first_grant", DW'(owner), DW'(0));
    run_until_idle(30);
    p_plan[3] = 1; p_plan[0] = 1;
    step(0); step(0);
    check_eq("t2_rr_grant", DW'(owner), DW'(3));
    run_until_idle(30);

    // Backpressure fills the skid
    step(1);
    p_plan[1] = 4; wr_pct = 0;
    repeat (6) step(0);
    check_eq("t3_full_ready", DW'(req_ready), DW'(0));
    wr_pct = 100;
    run_until_idle(30);

    // Owner stalls mid-burst while port 3 waits
    step(1);
    p_plan[0] = 3;
    step(0); step(0);
    p_pres[0] = 0; p_plan[3] = 2;
    repeat (10) step(0);
    check_eq("t4_port3_blocked", DW'(req_ready[3]), DW'(1'b0));
    check_eq("t4_owner_held", DW'(owner), DW'(0));
    p_pres[0] = 100;
    run_until_idle(40);

    // ID wrap over 257 single-descriptor bursts
    step(1);
    for (int k = 0; k < 257; k++) begin
      p_plan[k % N] = 1;
      run_until_idle(40);
    end
    check_eq("t5_id_wrapped", DW'(nid), DW'(1));

    // Reset in the middle of a burst
    step(1);
    p_plan[0] = 3;
    step(0); step(0);
    step(1);
    step(0);
    check_eq("t6_id_cleared", DW'(nid), DW'(0));
    check_eq("t6_valid_cleared", DW'(wrdm_valid), DW'(1'b0));
    p_plan[2] = 3;
    run_until_idle(30);

    // Random traffic
    for (int i = 0; i < N; i++) begin
      p_start[i] = 25; p_pres[i] = 75;
    end
    wr_pct = 65;
    repeat (3000) step(0);
    for (int i = 0; i < N; i++) begin
      p_start[i] = 0; p_pres[i] = 100;
    end
    wr_pct = 100;
    run_until_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wrdm_desc_arbiter.md
Name: wrdm_desc_arbiter

Overview:
- Shares the single PCIe write-data-mover (WRDM) descriptor port between NUM_PORTS DMA engines. Each engine is an fpga2cpu_pcie-style requester issuing data, data-wrap and completion descriptors.
- Arbitrates round-robin at burst granularity. A requester's burst (data [+wrap] + done descriptor) reaches WRDM contiguous and unbroken, which preserves per-queue completion ordering.
- Stamps a global descriptor ID on every descriptor and registers the output through a 2-entry skid buffer.

Parameters:
NUM_PORTS, 4, number of requesters (>=2)
DESC_WIDTH, 174, WRDM descriptor width (pcie_desc_t)
ID_WIDTH, 8, descriptor ID counter width
OVERWRITE_ID, 1, 1 = replace desc_id field with internal counter; 0 = pass through

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  NUM_PORTS  per-port descriptor valid
req_data  in  NUM_PORTS*DESC_WIDTH  per-port descriptor, port i at [i*DESC_WIDTH +: DESC_WIDTH]
req_last  in  NUM_PORTS  descriptor ends this port's burst
req_ready  out  NUM_PORTS  per-port accept
wrdm_desc_valid  out  1  descriptor valid to WRDM
wrdm_desc_data  out  DESC_WIDTH  descriptor to WRDM
wrdm_desc_ready  in  1  WRDM accept
owner  out  $clog2(NUM_PORTS)  current/last granted port
locked  out  1  burst in progress
next_desc_id  out  ID_WIDTH  ID the next accepted descriptor receives

Behaviour:
- Handshakes:
  - Transfer on req_valid[i] & req_ready[i] in the same cycle.
  - Transfer on wrdm_desc_valid & wrdm_desc_ready in the same cycle.
  - Once valid is asserted, data is held until transfer, on both sides.
- Reset values: req_ready=0, wrdm_desc_valid=0, wrdm_desc_data=0, owner=0, locked=0, next_desc_id=0, rr pointer=0, skid empty.
- FSM states: IDLE, LOCKED.
- IDLE:
  - If any req_valid, grant g = first set bit searching from rr_ptr upward, modulo NUM_PORTS.
  - Register owner<=g and locked<=1, then go to LOCKED.
  - No descriptor is accepted in IDLE. Arbitration costs one cycle per burst.
- LOCKED:
  - req_ready[owner] = skid not full. Every other req_ready bit is 0.
  - On an accepted descriptor with req_last=1: rr_ptr<=owner+1 mod NUM_PORTS, locked<=0, return to IDLE.
  - The owner deasserting req_valid mid-burst does not release the lock and has no timeout. Other ports stall; no preemption.
- ID stamping:
  - Each accepted descriptor gets desc_id field = next_desc_id when OVERWRITE_ID=1.
  - next_desc_id increments by 1 per accepted descriptor and wraps 2^ID_WIDTH-1 -> 0.
  - The field position comes from the pcie_desc_t struct. All other fields pass unchanged.
- Skid buffer:
  - 2 entries, FIFO order.
  - wrdm_desc_valid/data are driven from flops. req_ready is a function of registered occupancy only.
  - Minimum latency from accept to wrdm_desc_valid: 1 cycle.
  - Sustains 1 descriptor/cycle while wrdm_desc_ready=1.
  - Full (2 entries): req_ready=0. Simultaneous push and pop when full is not allowed; ready is already low.
  - Empty with a push: the entry becomes visible next cycle.
- Simultaneous events:
  - Burst end and a new request in the same cycle: the new grant resolves in the IDLE cycle that follows.
  - If the only requester is the one that just finished, it is granted again after the one IDLE cycle.
- Ordering: descriptors from one burst leave WRDM consecutively, with no interleaving from other ports.
- Reset mid-burst:
  - All state is cleared and skid contents are discarded.
  - Requesters are reset by the same rst, so no partial burst is resumed.
- Width rules:
  - rr_ptr and owner are $clog2(NUM_PORTS) bits, with explicit modulo wrap for non-power-of-2 NUM_PORTS.
  - ID counter is ID_WIDTH bits, unsigned wrap.

Decomposition:
- Shared package (existing my_struct_s): pcie_desc_t, WRDM_DESC_WIDTH=174, DESC_ID_WIDTH=8, arb_state_t {IDLE, LOCKED}.
- Sub-module desc_skid_buffer:
  - Parameterized 2-entry registered valid/ready stage, width DESC_WIDTH.
  - Reusable on the RDDM descriptor path.
- Round-robin priority pick is a local function, not a module.

Test Plan:
1. Single port: port 1 sends a 3-descriptor burst (data, wrap, done; last on done), wrdm_desc_ready=1 -> WRDM sees 3 consecutive descriptors with desc_id 0,1,2; first appears 2 cycles after req_valid rises (1 IDLE + 1 skid); locked drops after the 3rd accept.
2. Contention: ports 0 and 2 each present a 2-descriptor burst at the same cycle, rr_ptr=0 -> port 0's burst fully precedes port 2's, never interleaved; after both, rr_ptr=3; then port 3 and port 0 request together -> port 3 is granted first.
3. Backpressure: wrdm_desc_ready=0 for 5 cycles during a 4-descriptor burst -> req_ready[owner] drops once skid holds 2; no descriptor lost or duplicated; output order and IDs are unchanged when ready returns.
4. Owner stall: owner deasserts req_valid for 10 cycles mid-burst while port 3 requests -> req_ready[3]=0 throughout; port 3 is granted only after the owner's last descriptor is accepted.
5. ID wrap: drive 257 single-descriptor bursts -> IDs run 0..255,0; with OVERWRITE_ID=0 the input desc_id fields pass through unchanged.
6. Reset mid-burst: assert rst for 1 cycle after the 1st of 3 descriptors is accepted -> next cycle wrdm_desc_valid=0, locked=0, next_desc_id=0, all req_ready=0; a fresh burst from port 2 then completes normally with IDs starting at 0.
